// File: rtl/mux_pkg.sv
// Shared encodings and width helper for the N-to-1 arbitrated mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width never collapses to zero, even for a two-channel build.
    function automatic int calc_selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first requester above ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    always_comb begin
        logic found;
        int   idx;
        found      = 1'b0;
        idx        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        // ptr itself is visited last, so the previous winner has lowest priority.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = W'(idx);
            end
        end
        any = found;
    end

endmodule

// File: rtl/mux_n_one_arb.sv
// N-channel to one registered output, fixed-select or round-robin arbitration.
module mux_n_one_arb
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = calc_selw(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SELW-1:0]      rr_ptr;
    logic [N_CH-1:0]      rr_onehot;
    logic [SELW-1:0]      rr_idx;
    logic                 rr_any;
    logic [2**SELW-1:0]   vld_ext;
    logic                 can_load;
    logic                 gnt_valid;
    logic [SELW-1:0]      gnt_idx;
    logic                 take;

    rr_arbiter #(.N(N_CH), .W(SELW)) u_rr (
        .req        (in_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (rr_onehot),
        .gnt_idx    (rr_idx),
        .any        (rr_any)
    );

    always_comb begin
        vld_ext             = '0;
        vld_ext[N_CH-1:0]   = in_valid;
        can_load            = !out_valid || out_ready;
        gnt_valid           = 1'b0;
        gnt_idx             = '0;
        if (mode == MODE_RR) begin
            gnt_valid = rr_any;
            gnt_idx   = rr_idx;
        end else if (int'(sel) < N_CH && vld_ext[sel]) begin
            gnt_valid = 1'b1;
            gnt_idx   = sel;
        end
        take     = gnt_valid && can_load && !rst;
        in_ready = '0;
        // Ready is the only handshake gate, so a granted channel transfers exactly when take is high.
        if (take) begin
            if (mode == MODE_RR) begin
                in_ready = rr_onehot;
            end else begin
                for (int i = 0; i < N_CH; i++)
                    in_ready[i] = (gnt_idx == SELW'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SELW'(N_CH - 1);
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_ch    <= gnt_idx;
            if (mode == MODE_RR)
                rr_ptr <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_one_arb.sv
// Directed + random bench for mux_n_one_arb against a transaction-level model.
module tb_mux_n_one_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid, out_ready;

    // Five-channel instance: the only way to present an out-of-range select.
    logic [5*W-1:0]  in_data5;
    logic [4:0]      in_valid5, in_ready5;
    logic            mode5;
    logic [2:0]      sel5;
    logic [W-1:0]    out_data5;
    logic [2:0]      out_ch5;
    logic            out_valid5, out_ready5;

    int total = 0;
    int bad   = 0;

    bit          m_ov;
    logic [W-1:0] m_od;
    int          m_och;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_n_one_arb #(.N_CH(N), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n_one_arb #(.N_CH(5), .WIDTH(W)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
        .mode(mode5), .sel(sel5), .out_data(out_data5), .out_ch(out_ch5),
        .out_valid(out_valid5), .out_ready(out_ready5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant rule stated directly: blocked if held, reset, or nothing eligible.
    function automatic int model_grant();
        int c;
        if (rst || (m_ov && !out_ready)) return -1;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (in_valid[c]) return c;
            end
            return -1;
        end
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    task automatic tick();
        int           g;
        logic [N-1:0] er;
        @(negedge clk);
        g  = model_grant();
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 64'(in_ready), 64'(er));
        if (rst) begin
            m_ov = 0; m_od = '0; m_och = 0; m_ptr = N - 1;
        end else if (g >= 0) begin
            m_ov = 1; m_od = in_data[g*W +: W]; m_och = g;
            if (mode) m_ptr = g;
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_ch",    64'(out_ch),    64'(m_och));
        chk("out_data",  64'(out_data),  64'(m_od));
    endtask

    initial begin
        rst = 1; mode = 0; sel = '0; in_valid = '0; out_ready = 1; in_data = '0;
        in_data5 = '0; in_valid5 = '0; mode5 = 0; sel5 = '0; out_ready5 = 1;
        m_ov = 0; m_od = '0; m_och = 0; m_ptr = N - 1;
        #1;
        tick(); tick();
        chk("rst_ptr", 64'(u_dut.rr_ptr), 64'(3));
        rst = 0;

        // Fixed select of channel 2 with everything valid.
        mode = 0; sel = 2; in_valid = 4'b1111; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            tick();
            chk("t1_ch", 64'(out_ch), 64'(2));
        end

        // Round-robin from reset: 0,1,2,3,0 back to back.
        rst = 1; tick(); rst = 0;
        mode = 1; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            tick();
            chk("t2_ch", 64'(out_ch), 64'(i % 4));
            chk("t2_vld", 64'(out_valid), 64'(1));
        end

        // Sparse requesters alternate; idle channels stay not-ready.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            tick();
            chk("t3_ch", 64'(out_ch), 64'((i % 2) ? 3 : 1));
            chk("t3_idle", 64'(in_ready & 4'b0101), 64'(0));
        end

        // Hold 0xA5 under backpressure, then release.
        mode = 0; sel = 0; in_valid = 4'b0001; in_data = 32'h000000A5;
        tick();
        chk("t4_load", 64'(out_data), 64'h A5);
        out_ready = 0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick();
            chk("t4_hold", 64'(out_data), 64'h A5);
        end
        out_ready = 1; in_data = 32'h0000003C;
        tick();
        chk("t4_next", 64'(out_data), 64'h3C);

        // Out-of-range select on the five-channel instance.
        in_valid5 = 5'b11111; mode5 = 0; in_data5 = {5{8'h77}};
        for (int s = 5; s < 8; s++) begin
            sel5 = 3'(s);
            @(negedge clk);
            chk("t5_rdy", 64'(in_ready5), 64'(0));
            @(posedge clk); #1;
            chk("t5_vld", 64'(out_valid5), 64'(0));
        end
        in_valid5 = '0;

        // Reset while a word is held.
        mode = 1; in_valid = 4'b1111; out_ready = 0; in_data = $urandom;
        tick();
        chk("t6_pre", 64'(out_valid), 64'(1));
        rst = 1;
        tick();
        chk("t6_vld", 64'(out_valid), 64'(0));
        chk("t6_ptr", 64'(u_dut.rr_ptr), 64'(3));
        rst = 0; out_ready = 1; in_data = $urandom;
        tick();
        chk("t6_first", 64'(out_ch), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
